muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers. It sits in EX directly downstream of alu and consumes the same rs/rt operands. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in a single cycle. HI/LO feed the mfhi/mflo forwarding mux. busy drives the hazard unit's stall.

---
 rtl/muldiv_unit_if.sv | 15 +
 rtl/muldiv_unit.sv | 132 +++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; MTHI/MTLO complete in one cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic               launch;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;
    logic               is_div, neg_q, neg_r, div_zero;

    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo, quo, rem;
    logic [2*WIDTH-1:0] prod;

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        unique case (state)
            IDLE: if (bus.start && !bus.flush && !bus.op[2]) begin
                state_nxt = RUN;
                launch    = 1'b1;
            end
            RUN: begin
                if (bus.flush)          state_nxt = IDLE;
                else if (count == LAST) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sgn   = !bus.op[0];
        a_neg = sgn & bus.a[WIDTH-1];
        b_neg = sgn & bus.b[WIDTH-1];
        mag_a = a_neg ? -bus.a : bus.a;
        mag_b = b_neg ? -bus.b : bus.b;

        // Mul: {acc_hi,acc_lo} is the shifting product with the multiplier in acc_lo.
        // Div: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_diff = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, opnd};
        if (is_div) begin
            step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
            step_hi = div_diff[WIDTH+1] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]}
                                        : div_diff[WIDTH-1:0];
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end

        prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        // A zero divisor leaves quotient all ones and remainder |a|; only the remainder is re-signed.
        quo  = (neg_q && !div_zero) ? -acc_lo : acc_lo;
        rem  = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        count    <= '0;
                        is_div   <= bus.op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (bus.b == '0);
                        acc_hi   <= '0;
                        acc_lo   <= bus.op[1] ? mag_a : mag_b;
                        opnd     <= bus.op[1] ? mag_b : mag_a;
                    end else if (bus.start && !bus.flush) begin
                        if (bus.op == 3'd4)      hi_q <= bus.a;
                        else if (bus.op == 3'd5) lo_q <= bus.a;
                    end
                end
                RUN: if (!bus.flush) begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                end
                FIX: if (!bus.flush) begin
                    if (is_div) begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end else begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
